// File: rtl/wb_stage.sv
// Writeback stage: selects ALU result or (possibly slow) load data, issues a one-cycle
// register-file write, counts retirements and flags load timeouts. Optional: WB_BYPASS_EN.
module wb_stage #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int LOAD_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_data_valid,
    output logic              write_reg,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              load_err
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int TMO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_LOAD = 2'd2
    } state_t;

    state_t             state_reg;
    logic               write_reg_reg;
    logic [ADDR_W-1:0]  write_addr_reg;
    logic [DATA_W-1:0]  write_data_reg;
    logic [CNT_W-1:0]   retire_cnt_reg;
    logic               load_err_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic [ADDR_W-1:0]  pend_dest_reg;
    logic               pend_rw_reg;

    logic               accept;
    logic               direct_write;
    logic [DATA_W-1:0]  accept_data;

    assign in_ready     = (state_reg != ST_WAIT_LOAD);
    assign accept       = in_valid & in_ready;
    assign direct_write = ~in_mem_to_reg | load_data_valid;
    assign accept_data  = in_mem_to_reg ? load_data : in_alu_result;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            write_reg_reg  <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
            retire_cnt_reg <= '0;
            load_err_reg   <= 1'b0;
            tmo_cnt_reg    <= '0;
            pend_dest_reg  <= '0;
            pend_rw_reg    <= 1'b0;
        end else begin
            write_reg_reg <= 1'b0;
            // The instruction whose write pulse is shown this cycle retires at its end.
            if (state_reg == ST_WRITE) begin
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            end
            case (state_reg)
                ST_IDLE, ST_WRITE: begin
                    if (accept && direct_write) begin
                        write_addr_reg <= in_dest;
                        write_data_reg <= accept_data;
                        // r0 is hardwired zero, so writes to it are suppressed.
                        write_reg_reg  <= in_reg_write && (in_dest != '0);
                        state_reg      <= ST_WRITE;
                    end else if (accept) begin
                        pend_dest_reg <= in_dest;
                        pend_rw_reg   <= in_reg_write;
                        tmo_cnt_reg   <= '0;
                        state_reg     <= ST_WAIT_LOAD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (load_data_valid) begin
                        write_addr_reg <= pend_dest_reg;
                        write_data_reg <= load_data;
                        write_reg_reg  <= pend_rw_reg && (pend_dest_reg != '0);
                        state_reg      <= ST_WRITE;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        load_err_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign write_reg  = write_reg_reg;
    assign write_addr = write_addr_reg;
    assign write_data = write_data_reg;
    assign retire_cnt = retire_cnt_reg;
    assign load_err   = load_err_reg;

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding into decode; masked while reset is asserted.
    assign fwd_valid = write_reg_reg & rst;
    assign fwd_addr  = write_addr_reg;
    assign fwd_data  = write_data_reg;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_stage;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 3;
    localparam int LOAD_TIMEOUT = 15;
    localparam int CNT_W        = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [ADDR_W-1:0] in_dest;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] load_data;
    logic              load_data_valid;
    logic              write_reg;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [CNT_W-1:0]  retire_cnt;
    logic              load_err;
`ifdef WB_BYPASS_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_dest(in_dest), .in_alu_result(in_alu_result),
        .load_data(load_data), .load_data_valid(load_data_valid),
        .write_reg(write_reg), .write_addr(write_addr), .write_data(write_data),
        .retire_cnt(retire_cnt), .load_err(load_err)
`ifdef WB_BYPASS_EN
        , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A load either arrives within LOAD_TIMEOUT waiting cycles or is dropped.
    bit              m_live = 0;
    bit              m_waiting;
    int              m_waited;
    logic [ADDR_W-1:0] m_dest;
    bit              m_rw;
    bit              m_retiring;
    bit              e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [CNT_W-1:0]  e_cnt;
    bit              e_err;

    task automatic model_retire(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v, input bit rw);
        e_addr     = d;
        e_data     = v;
        e_wr       = rw && (d != 0);
        m_retiring = 1;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_waiting = 0; m_waited = 0; m_dest = 0; m_rw = 0; m_retiring = 0;
            e_wr = 0; e_addr = 0; e_data = 0; e_cnt = 0; e_err = 0;
            m_live = 1;
        end else begin
            if (m_retiring) e_cnt = e_cnt + 1'b1;
            m_retiring = 0;
            e_wr = 0;
            if (!m_waiting) begin
                if (in_valid) begin
                    if (!in_mem_to_reg)
                        model_retire(in_dest, in_alu_result, in_reg_write);
                    else if (load_data_valid)
                        model_retire(in_dest, load_data, in_reg_write);
                    else begin
                        m_waiting = 1; m_waited = 0; m_dest = in_dest; m_rw = in_reg_write;
                    end
                end
            end else if (load_data_valid) begin
                m_waiting = 0;
                model_retire(m_dest, load_data, m_rw);
            end else begin
                m_waited++;
                if (m_waited == LOAD_TIMEOUT) begin
                    m_waiting = 0;
                    e_err = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_in_ready", 32'(in_ready), 32'(!m_waiting));
            chk("model_write_reg", 32'(write_reg), 32'(e_wr));
            chk("model_write_addr", 32'(write_addr), 32'(e_addr));
            chk("model_write_data", 32'(write_data), 32'(e_data));
            chk("model_retire_cnt", 32'(retire_cnt), 32'(e_cnt));
            chk("model_load_err", 32'(load_err), 32'(e_err));
`ifdef WB_BYPASS_EN
            chk("model_fwd_valid", 32'(fwd_valid), 32'(e_wr && rst));
            chk("model_fwd_addr", 32'(fwd_addr), 32'(e_addr));
            chk("model_fwd_data", 32'(fwd_data), 32'(e_data));
`endif
            if (write_reg === 1'b1)
                $display("write r%0d <= %02h (retired so far %0d)", write_addr, write_data, retire_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit rw, input bit m2r, input int dest,
                         input int alu, input bit ldv, input int ld);
        in_valid        = v;
        in_reg_write    = rw;
        in_mem_to_reg   = m2r;
        in_dest         = ADDR_W'(dest);
        in_alu_result   = DATA_W'(alu);
        load_data_valid = ldv;
        load_data       = DATA_W'(ld);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    int ldv_pct;

    initial begin
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;

        // Reset hold
        @(negedge clk);
        chk("reset_write_reg", 32'(write_reg), 32'd0);
        chk("reset_write_addr", 32'(write_addr), 32'd0);
        chk("reset_write_data", 32'(write_data), 32'd0);
        chk("reset_retire_cnt", 32'(retire_cnt), 32'd0);
        chk("reset_load_err", 32'(load_err), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // ALU write
        drive(1, 1, 0, 2, 8'h03, 0, 0);
        step();
        idle();
        @(negedge clk);
        chk("alu_write_reg", 32'(write_reg), 32'd1);
        chk("alu_write_addr", 32'(write_addr), 32'd2);
        chk("alu_write_data", 32'(write_data), 32'h03);
        step();
        @(negedge clk);
        chk("alu_write_reg_drop", 32'(write_reg), 32'd0);
        chk("alu_retire_cnt", 32'(retire_cnt), 32'd1);

        // Back-to-back
        drive(1, 1, 0, 1, 8'h05, 0, 0);
        step();
        drive(1, 1, 0, 3, 8'h07, 0, 0);
        @(negedge clk);
        chk("b2b_first_wr", 32'(write_reg), 32'd1);
        chk("b2b_first_pair", 32'({write_addr, write_data}), 32'({3'd1, 8'h05}));
        step();
        idle();
        @(negedge clk);
        chk("b2b_second_wr", 32'(write_reg), 32'd1);
        chk("b2b_second_pair", 32'({write_addr, write_data}), 32'({3'd3, 8'h07}));
        step();
        @(negedge clk);
        chk("b2b_retire_cnt", 32'(retire_cnt), 32'd3);

        // Slow load: data arrives in the third waiting cycle
        drive(1, 1, 1, 4, 0, 0, 0);
        step();
        idle();
        @(negedge clk);
        chk("slow_ready_w1", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("slow_ready_w2", 32'(in_ready), 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 1, 8'h9A);
        @(negedge clk);
        chk("slow_ready_w3", 32'(in_ready), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("slow_write_reg", 32'(write_reg), 32'd1);
        chk("slow_write_pair", 32'({write_addr, write_data}), 32'({3'd4, 8'h9A}));
        chk("slow_ready_back", 32'(in_ready), 32'd1);
        step();
        @(negedge clk);
        chk("slow_retire_cnt", 32'(retire_cnt), 32'd4);

        // Load timeout: 15 waiting cycles, then error and back to ready
        drive(1, 1, 1, 6, 0, 0, 0);
        step();
        idle();
        for (int i = 0; i < LOAD_TIMEOUT - 1; i++) begin
            @(negedge clk);
            chk("tmo_still_waiting", 32'({in_ready, load_err}), 32'd0);
            step();
        end
        @(negedge clk);
        chk("tmo_last_wait_cycle", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("tmo_load_err", 32'(load_err), 32'd1);
        chk("tmo_in_ready", 32'(in_ready), 32'd1);
        chk("tmo_no_write", 32'(write_reg), 32'd0);
        chk("tmo_retire_cnt", 32'(retire_cnt), 32'd4);

        // ALU op to r0: no write pulse, still retires
        drive(1, 1, 0, 0, 8'hFF, 0, 0);
        step();
        idle();
        @(negedge clk);
        chk("r0_write_reg", 32'(write_reg), 32'd0);
        step();
        @(negedge clk);
        chk("r0_retire_cnt", 32'(retire_cnt), 32'd5);
        chk("r0_err_sticky", 32'(load_err), 32'd1);

        // Reset in the middle of a load wait
        drive(1, 1, 1, 5, 0, 0, 0);
        step();
        idle();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 8'h33);
        step();
        idle();
        @(negedge clk);
        chk("midrst_write_reg", 32'(write_reg), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_retire_cnt", 32'(retire_cnt), 32'd0);
        chk("midrst_load_err", 32'(load_err), 32'd0);

        // Randomized traffic
        ldv_pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 256 == 0) begin
                case ($urandom_range(0, 3))
                    0: ldv_pct = 3;
                    1: ldv_pct = 10;
                    2: ldv_pct = 40;
                    default: ldv_pct = 85;
                endcase
            end
            rst             = ($urandom_range(0, 299) != 0);
            in_valid        = ($urandom_range(0, 3) != 0);
            in_reg_write    = ($urandom_range(0, 7) != 0);
            in_mem_to_reg   = $urandom_range(0, 1);
            in_dest         = ADDR_W'($urandom_range(0, 7));
            in_alu_result   = DATA_W'($urandom_range(0, 255));
            load_data       = DATA_W'($urandom_range(0, 255));
            load_data_valid = ($urandom_range(0, 99) < ldv_pct);
            step();
        end
        rst = 1'b1;
        idle();
        repeat (LOAD_TIMEOUT + 3) step();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
